// File: rtl/fpna_pkg.sv
// fpna_pkg: shared sizing helpers and arithmetic for the LIF neuron array.
//   cfg_block_len / cfg_len : per-neuron and total config chain lengths
//   W_OFS / leak_ofs / thr_ofs : field offsets inside one neuron block
//   thr_max / THR_RESET        : largest positive potential (threshold reset value)
//   sat                        : clamp a wide accumulator to a signed POT_BITS range
package fpna_pkg;

    localparam int DEF_N_NEURONS = 4;
    localparam int DEF_N_INPUTS  = 4;
    localparam int DEF_W_BITS    = 4;
    localparam int DEF_POT_BITS  = 8;

    localparam int LEAK_BITS = 2;
    localparam int REFR_BITS = 4;

    // Weights occupy the low end of each block, weight j at j*W_BITS.
    localparam int W_OFS = 0;

    function automatic int leak_ofs(input int n_inputs, input int w_bits);
        return W_OFS + n_inputs * w_bits;
    endfunction

    function automatic int thr_ofs(input int n_inputs, input int w_bits);
        return leak_ofs(n_inputs, w_bits) + LEAK_BITS;
    endfunction

    function automatic int cfg_block_len(input int pot_bits, input int n_inputs,
                                         input int w_bits);
        return pot_bits + LEAK_BITS + n_inputs * w_bits;
    endfunction

    function automatic int cfg_len(input int n_neurons, input int pot_bits,
                                   input int n_inputs, input int w_bits);
        return n_neurons * cfg_block_len(pot_bits, n_inputs, w_bits);
    endfunction

    function automatic int thr_max(input int pot_bits);
        return (1 << (pot_bits - 1)) - 1;
    endfunction

    localparam int THR_RESET = thr_max(DEF_POT_BITS);

    function automatic int sat(input int acc, input int pot_bits);
        int hi;
        int lo;
        hi = thr_max(pot_bits);
        lo = -hi - 1;
        if (acc > hi) begin
            return hi;
        end
        if (acc < lo) begin
            return lo;
        end
        return acc;
    endfunction

endpackage

// File: rtl/fpna_lif_array_if.sv
// fpna_lif_array_if: pin-level bundle of the LIF array.
//   step, spike_in          : timestep strobe and input spike vector
//   cfg_en, cfg_data, cfg_out : bit-serial config chain in/out
//   spike_out, spike_valid  : registered spike pulses and step-complete pulse
//   mon_sel, mon_pot        : potential monitor select and value
// master drives the stimulus side, slave is the array.
interface fpna_lif_array_if #(
    parameter int N_NEURONS = 4,
    parameter int N_INPUTS  = 4,
    parameter int POT_BITS  = 8
);
    localparam int SEL_BITS = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

    logic                 step;
    logic [N_INPUTS-1:0]  spike_in;
    logic                 cfg_en;
    logic                 cfg_data;
    logic                 cfg_out;
    logic [N_NEURONS-1:0] spike_out;
    logic                 spike_valid;
    logic [SEL_BITS-1:0]  mon_sel;
    logic [POT_BITS-1:0]  mon_pot;

    modport master (
        output step, spike_in, cfg_en, cfg_data, mon_sel,
        input  cfg_out, spike_out, spike_valid, mon_pot
    );

    modport slave (
        input  step, spike_in, cfg_en, cfg_data, mon_sel,
        output cfg_out, spike_out, spike_valid, mon_pot
    );

endinterface

// File: rtl/fpna_lif_neuron.sv
// fpna_lif_neuron: one leaky integrate-and-fire neuron.
//   clk, reset : clock, synchronous active-high reset
//   step_en    : perform one timestep update this cycle
//   weights    : N_INPUTS signed weights, weight j at [j*W_BITS +: W_BITS]
//   thr, leak  : signed firing threshold, leak shift (0 = no leak)
//   spike_in   : input spikes for this timestep
//   v          : membrane potential (signed)
//   spike      : one-cycle spike pulse, registered
module fpna_lif_neuron
    import fpna_pkg::*;
#(
    parameter int N_INPUTS      = 4,
    parameter int W_BITS        = 4,
    parameter int POT_BITS      = 8,
    parameter int REFRAC_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         step_en,
    input  logic [N_INPUTS*W_BITS-1:0]   weights,
    input  logic [POT_BITS-1:0]          thr,
    input  logic [LEAK_BITS-1:0]         leak,
    input  logic [N_INPUTS-1:0]          spike_in,
    output logic [POT_BITS-1:0]          v,
    output logic                         spike
);

    // Wide enough that the leak term plus every weight can never overflow
    // before saturation.
    localparam int ACC_BITS = POT_BITS + W_BITS + $clog2(N_INPUTS) + 1;
    localparam logic [REFR_BITS-1:0] REFR_LOAD = REFR_BITS'(REFRAC_CYCLES);

    logic [REFR_BITS-1:0]        refr;
    logic signed [POT_BITS-1:0]  v_s;
    logic signed [POT_BITS-1:0]  thr_s;
    logic signed [POT_BITS-1:0]  leak_term;
    logic signed [W_BITS-1:0]    w_j;
    logic signed [ACC_BITS-1:0]  acc;
    logic signed [ACC_BITS-1:0]  term_ext;
    int                          acc_i;
    int                          sat_i;
    logic                        fire;

    assign v_s   = $signed(v);
    assign thr_s = $signed(thr);

    always_comb begin
        leak_term = '0;
        w_j       = '0;
        if (leak != '0) begin
            leak_term = v_s >>> leak;
        end
        acc      = ACC_BITS'(v_s);
        term_ext = ACC_BITS'(leak_term);
        acc      = acc - term_ext;
        for (int j = 0; j < N_INPUTS; j++) begin
            w_j      = $signed(weights[j*W_BITS +: W_BITS]);
            term_ext = ACC_BITS'(w_j);
            if (spike_in[j]) begin
                acc = acc + term_ext;
            end
        end
        acc_i = int'(acc);
        sat_i = sat(acc_i, POT_BITS);
        fire  = (sat_i >= int'(thr_s));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v     <= '0;
            refr  <= '0;
            spike <= 1'b0;
        end else if (step_en) begin
            spike <= 1'b0;
            if (refr != '0) begin
                refr <= refr - 1'b1;
                v    <= '0;
            end else if (fire) begin
                spike <= 1'b1;
                v     <= '0;
                refr  <= REFR_LOAD;
            end else begin
                v <= POT_BITS'(sat_i);
            end
        end else begin
            spike <= 1'b0;
        end
    end

endmodule

// File: rtl/fpna_lif_array.sv
// fpna_lif_array: parametrised array of LIF neurons with a bit-serial config chain.
//   clk, reset : clock, synchronous active-high reset
//   bus        : fpna_lif_array_if.slave (step/spike_in, cfg chain, spike_out,
//                spike_valid, potential monitor)
// Chain layout, MSB first: block[N_NEURONS-1] .. block[0], each block being
// {thr, leak, w[N_INPUTS-1] .. w[0]}. Config shifting outranks step.
module fpna_lif_array
    import fpna_pkg::*;
#(
    parameter int N_NEURONS     = 4,
    parameter int N_INPUTS      = 4,
    parameter int W_BITS        = 4,
    parameter int POT_BITS      = 8,
    parameter int REFRAC_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    fpna_lif_array_if.slave bus
);

    localparam int BLK     = cfg_block_len(POT_BITS, N_INPUTS, W_BITS);
    localparam int CFG_LEN = cfg_len(N_NEURONS, POT_BITS, N_INPUTS, W_BITS);
    localparam int WB      = N_INPUTS * W_BITS;
    localparam int LEAK_O  = leak_ofs(N_INPUTS, W_BITS);
    localparam int THR_O   = thr_ofs(N_INPUTS, W_BITS);

    // Zero weights and leak, every threshold at +max so nothing fires
    // until the chain is loaded.
    function automatic logic [CFG_LEN-1:0] chain_init();
        logic [CFG_LEN-1:0] c;
        c = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            c[i*BLK + THR_O +: POT_BITS] = POT_BITS'(thr_max(POT_BITS));
        end
        return c;
    endfunction

    localparam logic [CFG_LEN-1:0] CHAIN_RESET = chain_init();

    logic [CFG_LEN-1:0]   chain;
    logic                 step_en;
    logic                 spike_valid_q;
    logic [N_NEURONS-1:0] spike_vec;
    logic [POT_BITS-1:0]  v_all [N_NEURONS];
    logic [POT_BITS-1:0]  mon_pot_c;

    assign step_en = bus.step & ~bus.cfg_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= CHAIN_RESET;
        end else if (bus.cfg_en) begin
            chain <= {chain[CFG_LEN-2:0], bus.cfg_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            spike_valid_q <= 1'b0;
        end else begin
            spike_valid_q <= step_en;
        end
    end

    for (genvar i = 0; i < N_NEURONS; i++) begin : g_neuron
        fpna_lif_neuron #(
            .N_INPUTS      (N_INPUTS),
            .W_BITS        (W_BITS),
            .POT_BITS      (POT_BITS),
            .REFRAC_CYCLES (REFRAC_CYCLES)
        ) u_neuron (
            .clk      (clk),
            .reset    (reset),
            .step_en  (step_en),
            .weights  (chain[i*BLK + W_OFS +: WB]),
            .thr      (chain[i*BLK + THR_O +: POT_BITS]),
            .leak     (chain[i*BLK + LEAK_O +: LEAK_BITS]),
            .spike_in (bus.spike_in),
            .v        (v_all[i]),
            .spike    (spike_vec[i])
        );
    end

    // Out-of-range selects (non power-of-two arrays) read as zero.
    always_comb begin
        mon_pot_c = '0;
        if (int'(bus.mon_sel) < N_NEURONS) begin
            mon_pot_c = v_all[bus.mon_sel];
        end
    end

    assign bus.cfg_out     = chain[CFG_LEN-1];
    assign bus.spike_out   = spike_vec;
    assign bus.spike_valid = spike_valid_q;
    assign bus.mon_pot     = mon_pot_c;

endmodule

// File: tb/tb_fpna_lif_array.sv
module tb_fpna_lif_array;

    localparam int NN      = 4;
    localparam int NI      = 4;
    localparam int WBITS   = 4;
    localparam int PBITS   = 8;
    localparam int BLK     = PBITS + 2 + NI * WBITS;
    localparam int CFG_LEN = NN * BLK;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    logic [PBITS-1:0]   thr_cfg  [NN];
    logic [1:0]         leak_cfg [NN];
    logic [WBITS-1:0]   w_cfg    [NN][NI];
    logic [CFG_LEN-1:0] chain_model;
    logic [CFG_LEN-1:0] rst_chain;

    fpna_lif_array_if #(.N_NEURONS(NN), .N_INPUTS(NI), .POT_BITS(PBITS)) bus ();

    fpna_lif_array #(
        .N_NEURONS(NN), .N_INPUTS(NI), .W_BITS(WBITS), .POT_BITS(PBITS), .REFRAC_CYCLES(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic cfg_defaults();
        for (int n = 0; n < NN; n++) begin
            thr_cfg[n]  = 8'd127;
            leak_cfg[n] = 2'd0;
            for (int j = 0; j < NI; j++) w_cfg[n][j] = '0;
        end
    endtask

    function automatic logic [CFG_LEN-1:0] build_chain();
        logic [CFG_LEN-1:0] c;
        c = '0;
        for (int n = 0; n < NN; n++) begin
            for (int j = 0; j < NI; j++) c[n*BLK + j*WBITS +: WBITS] = w_cfg[n][j];
            c[n*BLK + NI*WBITS +: 2]     = leak_cfg[n];
            c[n*BLK + NI*WBITS + 2 +: 8] = thr_cfg[n];
        end
        return c;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.step = 1'b0;
        bus.cfg_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load_cfg();
        chain_model = build_chain();
        for (int i = 0; i < CFG_LEN; i++) begin
            @(negedge clk);
            bus.cfg_en   = 1'b1;
            bus.cfg_data = chain_model[CFG_LEN-1-i];
        end
        @(negedge clk);
        bus.cfg_en = 1'b0;
    endtask

    task automatic do_step(input logic [NI-1:0] spk);
        @(negedge clk);
        bus.step     = 1'b1;
        bus.spike_in = spk;
        @(negedge clk);
        bus.step = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.spike_out !== 4'b0 || bus.spike_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: spike_out=%b spike_valid=%b, want 0000/0", bus.spike_out, bus.spike_valid);
        end
        // k shifts done -> cfg_out shows reset-chain bit CFG_LEN-1-k (thr +127 = 0111_1111)
        for (int k = 0; k < CFG_LEN; k++) begin
            checks++;
            if (bus.cfg_out !== rst_chain[CFG_LEN-1-k]) begin
                errors++;
                $display("FAIL reset_chain_bit%0d: cfg_out=%b want %b", k, bus.cfg_out, rst_chain[CFG_LEN-1-k]);
            end
            bus.cfg_en   = 1'b1;
            bus.cfg_data = 1'b0;
            @(negedge clk);
        end
        bus.cfg_en = 1'b0;
        checks++;
        if (bus.cfg_out !== 1'b0 || bus.spike_out !== 4'b0) begin
            errors++;
            $display("FAIL zero_chain: cfg_out=%b spike_out=%b want 0/0000", bus.cfg_out, bus.spike_out);
        end
        for (int n = 0; n < NN; n++) begin
            bus.mon_sel = 2'(n);
            #1;
            checks++;
            if (bus.mon_pot !== 8'd0) begin
                errors++;
                $display("FAIL zero_pot%0d: mon_pot=%0d want 0", n, $signed(bus.mon_pot));
            end
        end
    endtask

    task automatic test_integrate();
        int exp_v [5] = '{3, 0, 0, 0, 3};
        logic exp_s [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        do_reset();
        cfg_defaults();
        w_cfg[0][0] = 4'd3;
        thr_cfg[0]  = 8'd5;
        load_cfg();
        bus.mon_sel = 2'd0;
        for (int s = 0; s < 5; s++) begin
            do_step(4'b0001);
            checks++;
            if (bus.mon_pot !== 8'(exp_v[s]) || bus.spike_out !== {3'b000, exp_s[s]} || bus.spike_valid !== 1'b1) begin
                errors++;
                $display("FAIL integrate_step%0d: v=%0d spike_out=%b valid=%b want v=%0d spike0=%b valid=1",
                         s + 1, $signed(bus.mon_pot), bus.spike_out, bus.spike_valid, exp_v[s], exp_s[s]);
            end
            @(negedge clk);
            checks++;
            if (bus.spike_out !== 4'b0 || bus.spike_valid !== 1'b0 || bus.mon_pot !== 8'(exp_v[s])) begin
                errors++;
                $display("FAIL integrate_idle%0d: v=%0d spike_out=%b valid=%b want v=%0d 0000 0",
                         s + 1, $signed(bus.mon_pot), bus.spike_out, bus.spike_valid, exp_v[s]);
            end
        end
    endtask

    task automatic test_saturation();
        int exp_p [7] = '{28, 56, 84, 112, 0, 0, 0};
        logic [3:0] exp_s [7] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
        int exp_n [6] = '{-32, -64, -96, -128, -128, -128};
        do_reset();
        cfg_defaults();
        for (int j = 0; j < NI; j++) w_cfg[1][j] = 4'd7;
        load_cfg();
        bus.mon_sel = 2'd1;
        for (int s = 0; s < 7; s++) begin
            do_step(4'b1111);
            checks++;
            if (bus.mon_pot !== 8'(exp_p[s]) || bus.spike_out !== exp_s[s]) begin
                errors++;
                $display("FAIL sat_pos_step%0d: v=%0d spike_out=%b want v=%0d spike_out=%b",
                         s + 1, $signed(bus.mon_pot), bus.spike_out, exp_p[s], exp_s[s]);
            end
        end
        do_reset();
        for (int j = 0; j < NI; j++) w_cfg[1][j] = 4'h8;
        load_cfg();
        for (int s = 0; s < 6; s++) begin
            do_step(4'b1111);
            checks++;
            if (bus.mon_pot !== 8'(exp_n[s]) || bus.spike_out !== 4'b0) begin
                errors++;
                $display("FAIL sat_neg_step%0d: v=%0d spike_out=%b want v=%0d 0000",
                         s + 1, $signed(bus.mon_pot), bus.spike_out, exp_n[s]);
            end
        end
    endtask

    task automatic test_leak();
        int exp_l [7] = '{32, 16, 8, 4, 2, 1, 1};
        do_reset();
        cfg_defaults();
        w_cfg[2][0] = 4'd7;
        w_cfg[2][1] = 4'd1;
        load_cfg();
        bus.mon_sel = 2'd2;
        for (int s = 0; s < 8; s++) do_step(4'b0011);
        checks++;
        if (bus.mon_pot !== 8'd64) begin
            errors++;
            $display("FAIL leak_preload: v=%0d want 64", $signed(bus.mon_pot));
        end
        leak_cfg[2] = 2'd1;
        load_cfg();
        checks++;
        if (bus.mon_pot !== 8'd64) begin
            errors++;
            $display("FAIL leak_cfg_keeps_v: v=%0d want 64", $signed(bus.mon_pot));
        end
        for (int s = 0; s < 7; s++) begin
            do_step(4'b0000);
            checks++;
            if (bus.mon_pot !== 8'(exp_l[s])) begin
                errors++;
                $display("FAIL leak_step%0d: v=%0d want %0d", s + 1, $signed(bus.mon_pot), exp_l[s]);
            end
        end
        leak_cfg[2] = 2'd0;
        w_cfg[2][0] = 4'hC;
        load_cfg();
        do_step(4'b0001);
        checks++;
        if (bus.mon_pot !== 8'hFD) begin
            errors++;
            $display("FAIL leak_neg_preload: v=%0d want -3", $signed(bus.mon_pot));
        end
        leak_cfg[2] = 2'd1;
        load_cfg();
        do_step(4'b0000);
        checks++;
        if (bus.mon_pot !== 8'hFF) begin
            errors++;
            $display("FAIL leak_neg: v=%0d want -1", $signed(bus.mon_pot));
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cfg_defaults();
        w_cfg[2][0] = 4'd1;
        load_cfg();
        bus.mon_sel = 2'd2;
        @(negedge clk);
        bus.step     = 1'b1;
        bus.spike_in = 4'b0001;
        for (int s = 1; s <= 4; s++) begin
            @(negedge clk);
            checks++;
            if (bus.mon_pot !== 8'(s) || bus.spike_valid !== 1'b1) begin
                errors++;
                $display("FAIL b2b_step%0d: v=%0d valid=%b want v=%0d valid=1", s, $signed(bus.mon_pot), bus.spike_valid, s);
            end
        end
        bus.step = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.mon_pot !== 8'd4 || bus.spike_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_hold: v=%0d valid=%b want v=4 valid=0", $signed(bus.mon_pot), bus.spike_valid);
        end
    endtask

    task automatic test_priority();
        logic [2:0] bits = 3'b101;
        do_reset();
        cfg_defaults();
        w_cfg[0][0] = 4'd5;
        thr_cfg[3]  = 8'b0101_1010;
        load_cfg();
        bus.mon_sel = 2'd0;
        do_step(4'b0001);
        checks++;
        if (bus.mon_pot !== 8'd5) begin
            errors++;
            $display("FAIL prio_setup: v=%0d want 5", $signed(bus.mon_pot));
        end
        for (int k = 1; k <= 3; k++) begin
            bus.step     = 1'b1;
            bus.cfg_en   = 1'b1;
            bus.cfg_data = bits[k-1];
            bus.spike_in = 4'b1111;
            @(negedge clk);
            checks++;
            if (bus.mon_pot !== 8'd5 || bus.spike_valid !== 1'b0 || bus.spike_out !== 4'b0 ||
                bus.cfg_out !== chain_model[CFG_LEN-1-k]) begin
                errors++;
                $display("FAIL prio_cycle%0d: v=%0d valid=%b spike_out=%b cfg_out=%b want 5/0/0000/%b",
                         k, $signed(bus.mon_pot), bus.spike_valid, bus.spike_out, bus.cfg_out, chain_model[CFG_LEN-1-k]);
            end
        end
        bus.step   = 1'b0;
        bus.cfg_en = 1'b0;
    endtask

    task automatic test_reset_mid_shift();
        do_reset();
        cfg_defaults();
        for (int n = 0; n < NN; n++) w_cfg[n][0] = 4'd7;
        load_cfg();
        do_step(4'b0001);
        bus.mon_sel = 2'd3;
        #1;
        checks++;
        if (bus.mon_pot !== 8'd7) begin
            errors++;
            $display("FAIL midrst_setup: v=%0d want 7", $signed(bus.mon_pot));
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            bus.cfg_en   = 1'b1;
            bus.cfg_data = 1'b1;
        end
        @(negedge clk);
        reset        = 1'b1;
        bus.step     = 1'b1;
        bus.spike_in = 4'b1111;
        @(negedge clk);
        reset      = 1'b0;
        bus.step   = 1'b0;
        bus.cfg_en = 1'b0;
        checks++;
        if (bus.spike_out !== 4'b0 || bus.spike_valid !== 1'b0 || bus.cfg_out !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs: spike_out=%b valid=%b cfg_out=%b want 0000/0/0", bus.spike_out, bus.spike_valid, bus.cfg_out);
        end
        for (int n = 0; n < NN; n++) begin
            bus.mon_sel = 2'(n);
            #1;
            checks++;
            if (bus.mon_pot !== 8'd0) begin
                errors++;
                $display("FAIL midrst_pot%0d: v=%0d want 0", n, $signed(bus.mon_pot));
            end
        end
        for (int s = 0; s < 3; s++) begin
            do_step(4'b1111);
            checks++;
            if (bus.spike_out !== 4'b0 || bus.spike_valid !== 1'b1 || bus.mon_pot !== 8'd0) begin
                errors++;
                $display("FAIL midrst_step%0d: spike_out=%b valid=%b v=%0d want 0000/1/0", s + 1, bus.spike_out, bus.spike_valid, $signed(bus.mon_pot));
            end
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (bus.cfg_out !== rst_chain[CFG_LEN-1-k]) begin
                errors++;
                $display("FAIL midrst_thr_bit%0d: cfg_out=%b want %b", k, bus.cfg_out, rst_chain[CFG_LEN-1-k]);
            end
            bus.cfg_en   = 1'b1;
            bus.cfg_data = 1'b0;
            @(negedge clk);
        end
        bus.cfg_en = 1'b0;
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        reset        = 1'b1;
        bus.step     = 1'b0;
        bus.spike_in = '0;
        bus.cfg_en   = 1'b0;
        bus.cfg_data = 1'b0;
        bus.mon_sel  = '0;
        cfg_defaults();
        rst_chain = build_chain();
        repeat (2) @(negedge clk);

        test_reset();
        test_integrate();
        test_saturation();
        test_leak();
        test_back_to_back();
        test_priority();
        test_reset_mid_shift();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpna_lif_array.md
Name: fpna_lif_array

Overview:
- Parametrised array of leaky integrate-and-fire neurons for the neurochip core. It generalises the fixed single-purpose top into configurable neuron count, input count, weight width and potential width.
- Weights, thresholds and leak are loaded over a bit-serial config chain sized for TinyTapeout pin limits.
- Neurons update on an external timestep strobe and emit one-cycle spike pulses.
- It sits between the tt_um_ input pins (spike inputs, config pins) and the uo_out/uio_out spike and monitor outputs.

Parameters:
- N_NEURONS, 4, number of neurons.
- N_INPUTS, 4, number of spike inputs; every neuron sees every input.
- W_BITS, 4, signed two's-complement weight width.
- POT_BITS, 8, signed membrane potential and threshold width.
- REFRAC_CYCLES, 2, timesteps a neuron stays silent after firing. Legal range 0..15.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high.
- step, input, 1, timestep strobe: one neuron update per high cycle.
- spike_in, input, N_INPUTS, input spike vector, sampled on step.
- cfg_en, input, 1, shift config chain one bit this cycle.
- cfg_data, input, 1, serial config bit.
- cfg_out, output, 1, chain MSB, for daisy-chaining.
- spike_out, output, N_NEURONS, registered spike pulses.
- spike_valid, output, 1, pulses with every completed timestep.
- mon_sel, input, clog2(N_NEURONS) (min 1), neuron index to monitor.
- mon_pot, output, POT_BITS, potential of neuron mon_sel, combinational from state.

Behaviour:

Config chain:
- Length CFG_LEN = N_NEURONS*(POT_BITS+2+N_INPUTS*W_BITS).
- Per-neuron block, MSB to LSB: {thr[POT_BITS-1:0], leak[1:0], w[N_INPUTS-1] .. w[0]}.
- Chain is {block[N_NEURONS-1], ..., block[0]}.
- On cfg_en: chain <= {chain[CFG_LEN-2:0], cfg_data}. Bits are sent MSB-first, neuron N_NEURONS-1 first, CFG_LEN cycles total.
- cfg_out = chain[CFG_LEN-1].

Reset (synchronous):
- All weights 0, leak 0, thresholds +max (2^(POT_BITS-1)-1).
- All potentials 0, refractory counters 0.
- spike_out 0, spike_valid 0.
- Reset overrides cfg_en and step in the same cycle. A partially shifted chain is discarded.

Timestep (step=1 and cfg_en=0), per neuron i, all computed in parallel:
- If refr[i] != 0: refr[i]--, v[i] <= 0, no spike.
- Else:
  - leak_term = 0 if leak==0, otherwise v>>>leak (arithmetic shift, rounds toward -inf).
  - acc = v - leak_term + sum over j of (spike_in[j] ? w[i][j] : 0).
  - acc is computed at POT_BITS+W_BITS+clog2(N_INPUTS)+1 bits, then saturated to the POT_BITS signed range.
  - If sat >= thr: spike_out[i] <= 1, v <= 0, refr <= REFRAC_CYCLES.
  - Else: v <= sat.

Timing and handshake:
- spike_out and spike_valid go high the cycle after step is sampled, for exactly one cycle. Latency is 1.
- step with cfg_en=1: step is ignored, no update, spike_valid stays 0. Config takes priority.
- step=0: potentials hold; spike_out and spike_valid are 0.
- Back-to-back steps update every cycle.
- Config shifting does not disturb potentials or refractory counters. New config takes effect on the next step.
- A threshold <= 0 is legal: the neuron fires on any step where sat >= thr.

Decomposition:
- Package fpna_pkg holds:
  - cfg_block_len(), cfg_len() functions.
  - field-offset localparams.
  - sat() helper function.
  - THR_RESET constant.
- Sub-module fpna_lif_neuron, one per neuron via generate:
  - inputs: weights, thr, leak, spike_in, step_en.
  - outputs: v, spike.
  - contains the refractory counter.
- The top holds the config chain, spike_valid and the monitor mux.

Test Plan:
1. Reset, then 104 cfg_en cycles with all zeros. No steps fired. Expect: cfg_out = 0, mon_pot = 0, spike_out = 0.
2. Neuron 0: w0=3, thr=5, leak=0. Steps with spike_in=0001:
   - mon_pot goes 3, then spike_out[0]=1 on the 2nd step (6 >= 5) and v=0.
   - Next 2 steps: no spike, v stays 0.
   - 5th step: v=3.
3. Saturation: neuron 1 all w=7, thr=127, spike_in=1111.
   - v goes 28, 56, 84, 112.
   - 5th step saturates to 127: spike_out[1] pulses once.
   - With all w=-8, v floors at -128 and never wraps.
4. Leak: leak=1, thr=127, neuron preloaded to v=64 via inputs, then steps with spike_in=0.
   - mon_pot goes 32, 16, 8, 4, 2, 1, 1.
   - v=-3 with leak 1 goes to -1.
5. Priority: step and cfg_en both high for 3 cycles. Expect: no potential change, spike_valid stays 0, chain shifted 3 bits.
6. Reset asserted mid-shift at bit 50 with step high. Next cycle: all outputs 0, thresholds +127; subsequent steps produce no spikes with zero weights.
